// File: rtl/rs_alu_issue_sched_pkg.sv
// Shared constants and types for the ALU reservation station.
package rs_alu_issue_sched_pkg;

    localparam int unsigned RS_DEPTH = 8;
    localparam int unsigned IDX_W    = $clog2(RS_DEPTH);

    typedef logic [IDX_W-1:0]    rs_idx_t;
    typedef logic [RS_DEPTH-1:0] rs_vec_t;
    typedef logic [IDX_W:0]      rs_cnt_t;

    // Entry index to one-hot entry mask.
    function automatic rs_vec_t idx_to_oh(input rs_idx_t idx);
        return rs_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rs_alu_issue_sched_if.sv
// Dispatch, wakeup and issue signals of the ALU issue scheduler.
interface rs_alu_issue_sched_if;
    import rs_alu_issue_sched_pkg::*;

    logic    flush_i;
    logic    alloc_valid_first_i;
    logic    alloc_valid_second_i;
    logic    alloc_ready_first_o;
    logic    alloc_ready_second_o;
    rs_idx_t alloc_idx_first_o;
    rs_idx_t alloc_idx_second_o;
    rs_vec_t entry_ready_i;
    logic    alu1_ready_i;
    logic    alu2_ready_i;
    logic    alu1_issue_valid_o;
    rs_idx_t alu1_issue_idx_o;
    logic    alu2_issue_valid_o;
    rs_idx_t alu2_issue_idx_o;
    rs_cnt_t occupancy_o;

    // Scheduler side.
    modport slave (
        input  flush_i, alloc_valid_first_i, alloc_valid_second_i,
        input  entry_ready_i, alu1_ready_i, alu2_ready_i,
        output alloc_ready_first_o, alloc_ready_second_o,
        output alloc_idx_first_o, alloc_idx_second_o,
        output alu1_issue_valid_o, alu1_issue_idx_o,
        output alu2_issue_valid_o, alu2_issue_idx_o,
        output occupancy_o
    );

    // Dispatch / ALU / RS storage side.
    modport master (
        output flush_i, alloc_valid_first_i, alloc_valid_second_i,
        output entry_ready_i, alu1_ready_i, alu2_ready_i,
        input  alloc_ready_first_o, alloc_ready_second_o,
        input  alloc_idx_first_o, alloc_idx_second_o,
        input  alu1_issue_valid_o, alu1_issue_idx_o,
        input  alu2_issue_valid_o, alu2_issue_idx_o,
        input  occupancy_o
    );

endinterface

// File: rtl/rs_alu_issue_sched_age_select.sv
// Age-matrix picker: oldest and second-oldest candidate, purely combinational.
// i_age[i][j] = 1 means entry i is older than entry j.
module rs_age_select #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
    input  logic [DEPTH-1:0]            i_cand,
    output logic [DEPTH-1:0]            o_sel1_oh,
    output logic [DEPTH-1:0]            o_sel2_oh,
    output logic [IW-1:0]               o_sel1_idx,
    output logic [IW-1:0]               o_sel2_idx,
    output logic                        o_sel1_valid,
    output logic                        o_sel2_valid
);

    logic [DEPTH-1:0] w_cand2;

    // A candidate wins when no other candidate is older than it.
    function automatic logic [DEPTH-1:0] pick_oldest(
        input logic [DEPTH-1:0]            cand,
        input logic [DEPTH-1:0][DEPTH-1:0] age
    );
        logic [DEPTH-1:0] oh;
        logic [DEPTH-1:0] older;
        oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            older = '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j != i) older[j] = age[j][i];
            end
            oh[i] = cand[i] && !(|(older & cand));
        end
        return oh;
    endfunction

    function automatic logic [IW-1:0] oh_to_idx(input logic [DEPTH-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (oh[i]) idx = idx | IW'(i);
        end
        return idx;
    endfunction

    // Oldest pick, then the same rule with the oldest removed.
    always_comb begin
        o_sel1_oh    = pick_oldest(i_cand, i_age);
        w_cand2      = i_cand & ~o_sel1_oh;
        o_sel2_oh    = pick_oldest(w_cand2, i_age);
        o_sel1_idx   = oh_to_idx(o_sel1_oh);
        o_sel2_idx   = oh_to_idx(o_sel2_oh);
        o_sel1_valid = |i_cand;
        o_sel2_valid = |w_cand2;
    end

endmodule

// File: rtl/rs_alu_issue_sched.sv
// ALU reservation-station issue scheduler: slot occupancy, age order, issue grant.
module rs_alu_issue_sched
    import rs_alu_issue_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rs_alu_issue_sched_if.slave   bus
);

    rs_vec_t                          r_valid;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_age;

    rs_idx_t w_free_idx1, w_free_idx2;
    logic    w_has_free1, w_has_free2;
    logic    w_alloc1, w_alloc2;
    rs_vec_t w_sel1_oh, w_sel2_oh;
    rs_idx_t w_sel1_idx, w_sel2_idx;
    logic    w_sel1_valid, w_sel2_valid;
    logic    w_iss1_valid, w_iss2_valid;
    logic    w_hs1, w_hs2;
    rs_vec_t w_clr, w_set;
    rs_cnt_t w_occ;

    // Lowest and second-lowest free entry from registered occupancy.
    always_comb begin
        w_free_idx1 = '0;
        w_free_idx2 = '0;
        w_has_free1 = 1'b0;
        w_has_free2 = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!r_valid[i]) begin
                if (!w_has_free1) begin
                    w_free_idx1 = rs_idx_t'(i);
                    w_has_free1 = 1'b1;
                end else if (!w_has_free2) begin
                    w_free_idx2 = rs_idx_t'(i);
                    w_has_free2 = 1'b1;
                end
            end
        end
    end

    // Number of valid entries.
    always_comb begin
        w_occ = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            w_occ = w_occ + rs_cnt_t'(r_valid[i]);
        end
    end

    rs_age_select #(.DEPTH(RS_DEPTH)) u_age_select (
        .i_age        (r_age),
        .i_cand       (r_valid & bus.entry_ready_i),
        .o_sel1_oh    (w_sel1_oh),
        .o_sel2_oh    (w_sel2_oh),
        .o_sel1_idx   (w_sel1_idx),
        .o_sel2_idx   (w_sel2_idx),
        .o_sel1_valid (w_sel1_valid),
        .o_sel2_valid (w_sel2_valid)
    );

    // Issue offers, allocation grants and per-entry clear/set masks.
    always_comb begin
        w_iss1_valid = w_sel1_valid && !bus.flush_i;
        w_iss2_valid = w_sel2_valid && !bus.flush_i;
        w_hs1        = w_iss1_valid && bus.alu1_ready_i;
        w_hs2        = w_iss2_valid && bus.alu2_ready_i;
        w_alloc1     = bus.alloc_valid_first_i && w_has_free1;
        w_alloc2     = bus.alloc_valid_second_i && w_has_free2;
        w_clr        = (w_hs1 ? w_sel1_oh : '0) | (w_hs2 ? w_sel2_oh : '0);
        w_set        = (w_alloc1 ? idx_to_oh(w_free_idx1) : '0)
                     | (w_alloc2 ? idx_to_oh(w_free_idx2) : '0);
    end

    assign bus.alloc_ready_first_o  = w_has_free1;
    assign bus.alloc_ready_second_o = w_has_free2;
    assign bus.alloc_idx_first_o    = w_free_idx1;
    assign bus.alloc_idx_second_o   = w_free_idx2;
    assign bus.alu1_issue_valid_o   = w_iss1_valid;
    assign bus.alu2_issue_valid_o   = w_iss2_valid;
    assign bus.alu1_issue_idx_o     = w_iss1_valid ? w_sel1_idx : '0;
    assign bus.alu2_issue_idx_o     = w_iss2_valid ? w_sel2_idx : '0;
    assign bus.occupancy_o          = w_occ;

    // Occupancy and age matrix update; a new entry is younger than every live one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_age   <= '0;
        end else if (bus.flush_i) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_clr) | w_set;
            if (w_alloc1) begin
                for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                    r_age[j][w_free_idx1] <= r_valid[j];
                    r_age[w_free_idx1][j] <= 1'b0;
                end
            end
            if (w_alloc2) begin
                for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                    r_age[j][w_free_idx2] <= r_valid[j];
                    r_age[w_free_idx2][j] <= 1'b0;
                end
            end
            // Slot 1 is older than slot 2 when both land together; this write must win.
            if (w_alloc1 && w_alloc2) begin
                r_age[w_free_idx1][w_free_idx2] <= 1'b1;
            end
        end
    end

    a_alloc1_free: assert property (@(posedge clk) disable iff (!rst)
        w_has_free1 |-> !r_valid[w_free_idx1]);
    a_alloc2_free: assert property (@(posedge clk) disable iff (!rst)
        w_has_free2 |-> !r_valid[w_free_idx2]);
    a_sel_distinct: assert property (@(posedge clk) disable iff (!rst)
        (w_iss1_valid && w_iss2_valid) |-> (w_sel1_idx != w_sel2_idx));
    a_occupancy: assert property (@(posedge clk) disable iff (!rst)
        w_occ == rs_cnt_t'($countones(r_valid)));

endmodule

// File: doc/rs_alu_issue_sched.md
Name: rs_alu_issue_sched

Overview:
Age-ordered issue scheduler for the ALU reservation station. It allocates entry slots for up to two dispatched instructions per cycle, tracks relative age with an age matrix, and selects the oldest and second-oldest operand-ready entries. It issues them to ALU1 and ALU2 with a valid/ready handshake. Entry payload storage and operand wakeup stay in the RS datapath; this block owns only slot occupancy, age order and issue grant.

Parameters:
RS_DEPTH, 8, number of ALU RS entries; power of two, at least 4.
IDX_W, $clog2(RS_DEPTH), entry index width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
flush_i  in  1  pipeline flush; clears all entries
alloc_valid_first_i  in  1  dispatch slot 1 wants an entry (older than slot 2)
alloc_valid_second_i  in  1  dispatch slot 2 wants an entry
alloc_ready_first_o  out  1  at least 1 free entry
alloc_ready_second_o  out  1  at least 2 free entries
alloc_idx_first_o  out  IDX_W  entry index for slot 1 (lowest free index)
alloc_idx_second_o  out  IDX_W  entry index for slot 2 (second-lowest free index)
entry_ready_i  in  RS_DEPTH  per-entry "all operands ready", from RS storage
alu1_ready_i  in  1  ALU1 accepts a request
alu2_ready_i  in  1  ALU2 accepts a request
alu1_issue_valid_o  out  1  oldest ready entry offered to ALU1
alu1_issue_idx_o  out  IDX_W  its index
alu2_issue_valid_o  out  1  second-oldest ready entry offered to ALU2
alu2_issue_idx_o  out  IDX_W  its index
occupancy_o  out  IDX_W+1  number of valid entries

Behaviour:
- State: valid[RS_DEPTH]; age[i][j] (1 = entry i older than entry j), RS_DEPTH x RS_DEPTH bits, diagonal unused.
- Reset (rst=0, async): valid=0 and age=0.
- Resulting outputs with the station empty: issue valids 0, occupancy 0, alloc_ready both 1, alloc_idx_first=0, alloc_idx_second=1.
- Allocation:
  - Ready and index outputs depend only on registered valid; entries freed this cycle are not reusable until the next cycle.
  - A slot allocates on valid && ready.
  - Slot 2 always uses the second-lowest free index, even when slot 1 is idle.
  - New entry n: set valid[n]=1, age[j][n]=valid[j] for every existing j, age[n][*]=0.
  - When both slots allocate in the same cycle, also set age[first][second]=1.
- Selection (combinational):
  - cand = valid & entry_ready_i.
  - sel1 = the candidate with no older candidate.
  - sel2 = the same rule over cand with sel1 removed.
  - alu1_issue_valid_o = |cand && !flush_i; alu2_issue_valid_o = (at least 2 candidates) && !flush_i.
  - Issue valid must not depend on alu*_ready_i.
  - Index outputs are 0 when their valid is 0.
- Issue handshake:
  - Entry sel1 is freed at the edge where alu1_issue_valid_o && alu1_ready_i; likewise sel2 for ALU2.
  - The two ALUs complete independently; if only ALU2 accepts, the younger entry issues first, which is legal.
  - A freed entry's age row and column are don't-care; they are rewritten on reallocation.
- Latency: an entry allocated at edge T with entry_ready_i high can issue in the cycle after T, with handshake completing at edge T+1. Same-cycle alloc-to-issue bypass does not exist.
- Simultaneous alloc and free: legal and independent, since allocation only targets entries that are free in registered state.
- Flush: at the next edge, valid=0 regardless of same-cycle alloc or issue handshakes. Issue valids are forced 0 during the flush cycle.
- Full station: alloc_ready_first_o=0 and alloc_idx outputs don't-care. With RS_DEPTH-1 entries valid, only alloc_ready_first_o=1.
- Invariant (assert): an alloc_idx output never points to a valid entry.
- Invariant (assert): sel1 != sel2 whenever both valids are 1.
- Invariant (assert): occupancy_o equals popcount(valid).

Decomposition:
- rs_pkg: RS_DEPTH and IDX_W constants, plus an entry-index typedef, shared with rs_alu storage.
- Sub-module rs_age_select: age matrix plus candidate vector in, oldest and second-oldest one-hot and index out. Pure combinational, reusable for the LSU RS.
- Free-index picker (lowest and second-lowest zero) is inline logic.

Test Plan:
- Reset then idle: rst low mid-run with 5 entries valid -> all issue valids 0 immediately, occupancy 0, alloc_idx 0/1, alloc_ready 1/1.
- Age order: allocate A (slot1) and B (slot2) in cycle 0, then C in cycle 1 (indices 0, 1, 2); entry_ready=3'b111, both ALUs ready -> ALU1 gets idx 0 and ALU2 gets idx 1, then ALU1 gets idx 2.
- Non-index order: free idx 0, allocate D into idx 0 (youngest), ready only idx 0 and idx 2 -> ALU1 gets idx 2 and ALU2 gets idx 0.
- Backpressure: two ready entries, alu1_ready=0, alu2_ready=1 for 3 cycles -> ALU1 offer stays stable on the oldest entry; the younger issues on ALU2 and is freed after 1 edge.
- Full/near-full: fill 8 entries -> alloc_ready 0/0. Issue one -> next cycle 1/0, alloc_idx_first equals the freed index.
- Flush: 6 valid entries, flush_i with concurrent alloc_valid_first and ALU handshakes -> issue valids 0 during the flush cycle; occupancy 0 next cycle.
